sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO. Next generation of our 16x8 sync FIFO:

---
 rtl/sync_fifo_param.sv | 110 +++++++++++
 tb/tb_sync_fifo_param.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// sticky overflow/underflow errors, registered read data and synchronous flush.
module sync_fifo_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = 14,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        d_in,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        d_out,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] PtrOne  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] AfLevel = (ADDR_W + 1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AeLevel = (ADDR_W + 1)'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] d_out_q, d_out_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_acc, rd_acc;

  // Flags and count come only from the registered pointers.
  always_comb begin
    empty        = (wr_ptr_q == rd_ptr_q);
    full         = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    count        = wr_ptr_q - rd_ptr_q;
    almost_full  = (count >= AfLevel);
    almost_empty = (count <= AeLevel);
  end

  always_comb begin
    wr_acc      = wr_en && !full && !flush;
    rd_acc      = rd_en && !empty && !flush;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    d_out_d     = d_out_q;
    rd_valid_d  = rd_acc;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PtrOne;
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + PtrOne;
        d_out_d  = mem[rd_ptr_q[ADDR_W-1:0]];
      end
    end

    // Clear first so a same-cycle error event wins over clr_err.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && full && !flush)  overflow_d  = 1'b1;
    if (rd_en && empty && !flush) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      d_out_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      d_out_q     <= d_out_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q[ADDR_W-1:0]] <= d_in;
  end

  assign d_out     = d_out_q;
  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised scoreboard bench for sync_fifo_param (8x16, AF=14, AE=2) against a
// queue-based reference model.
module tb_sync_fifo_param;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] d_in = '0;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] d_out;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  sync_fifo_param #(
    .DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .d_in(d_in), .rd_en(rd_en),
    .d_out(d_out), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] model_q [$];
  logic [7:0] exp_q [$];
  logic       ovf_m = 1'b0;
  logic       udf_m = 1'b0;
  logic       exp_rv = 1'b0;
  logic [7:0] last_dout = 8'h00;
  int         max_count = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic chk_flags();
    int n;
    n = model_q.size();
    chk("count", int'(count), n);
    chk("empty", int'(empty), int'(n == 0));
    chk("full", int'(full), int'(n == DEPTH));
    chk("almost_full", int'(almost_full), int'(n >= 14));
    chk("almost_empty", int'(almost_empty), int'(n <= 2));
    chk("overflow", int'(overflow), int'(ovf_m));
    chk("underflow", int'(underflow), int'(udf_m));
    if (int'(count) > max_count) max_count = int'(count);
  endtask

  // One clock: drive at negedge, check pre-edge flags, advance the model.
  task automatic step(input logic wr, input logic [7:0] din, input logic rd,
                      input logic fl, input logic ce);
    logic wr_ok, rd_ok, was_full, was_empty;
    @(negedge clk);
    wr_en = wr; d_in = din; rd_en = rd; flush = fl; clr_err = ce;
    #1;
    chk_flags();
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    wr_ok = wr && !was_full && !fl;
    rd_ok = rd && !was_empty && !fl;
    if (ce) begin ovf_m = 1'b0; udf_m = 1'b0; end
    if (wr && was_full && !fl) ovf_m = 1'b1;
    if (rd && was_empty && !fl) udf_m = 1'b1;
    if (fl) model_q.delete();
    if (rd_ok) exp_q.push_back(model_q.pop_front());
    if (wr_ok) model_q.push_back(din);
    exp_rv = rd_ok;
    @(posedge clk);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset asserted mid-cycle; outputs must react without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    wr_en = 0; rd_en = 0; flush = 0; clr_err = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_empty", int'(empty), 1);
    chk("rst_count", int'(count), 0);
    chk("rst_dout", int'(d_out), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    model_q.delete();
    exp_q.delete();
    ovf_m = 0; udf_m = 0; exp_rv = 0; last_dout = 8'h00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: checks rd_valid against the model and pops the scoreboard on each strobe.
  always @(posedge clk) begin
    #2;
    chk("rd_valid", int'(rd_valid), int'(exp_rv));
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_read", 1, 0);
      end else begin
        last_dout = exp_q.pop_front();
        chk("d_out", int'(d_out), int'(last_dout));
      end
    end else begin
      chk("d_out_hold", int'(d_out), int'(last_dout));
    end
  end

  initial begin
    rst = 1'b1;
    #12 rst = 1'b0;

    // Reset, one push, reset again.
    do_reset();
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    idle();
    do_reset();
    idle();

    // Fill with 0x00..0x0F, then one push too many.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    idle();

    // Drain 16, then one pop too many.
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle();
    chk("hold_after_underflow", int'(d_out), 8'h0F);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle();

    // Simultaneous write+read at count 5, at full, and at empty.
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    idle();
    while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    idle();

    // Wrap: 3 pushes then 2 pops, 8 rounds.
    do_reset();
    max_count = 0;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
    idle();
    chk("max_count_bound", int'(max_count <= DEPTH), 1);

    // Flush at count 9 with a write pending.
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    idle();
    chk("flush_empty", int'(empty), 1);

    // clr_err together with a write into a full FIFO keeps overflow set.
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
    idle();
    chk("ovf_set_wins", int'(overflow), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle();

    // Random traffic with occasional flush and clr_err.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 5));
    end
    while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
